// File: rtl/issue_fifo_param.sv
// Parametrised issue FIFO for {cmd, addr, bank} words, with occupancy, early full and sticky error flags.
// Optional same-cycle bypass of an empty FIFO is enabled by defining ISSUE_FIFO_BYPASS_EN.
module issue_fifo_param #(
  parameter int unsigned WIDTH        = 21,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned FULL_MARGIN  = 4,
  parameter int unsigned VFULL_MARGIN = 8,
  parameter int unsigned AW           = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ren,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_out_pre,
  output logic             full,
  output logic             virtual_full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr_pre;
  logic [AW:0]      free;
  logic             bypass;
  logic             pop_ok;
  logic             push_ok;
  logic             store_en;

  // A bypassed push/pop pair travels straight from data_in to the consumer and skips storage.
  always_comb begin
    bypass = 1'b0;
`ifdef ISSUE_FIFO_BYPASS_EN
    bypass = wen && (count == '0);
`endif
    pop_ok   = ren && ((count != '0) || bypass);
    push_ok  = wen && ((count != DEPTH_C) || pop_ok);
    store_en = push_ok && !(bypass && pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) storage[i] <= '0;
    end else if (store_en) begin
      storage[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
      else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
      if (wen && !push_ok) overflow <= 1'b1;
      if (ren && (count == '0) && !bypass) underflow <= 1'b1;
    end
  end

  always_comb begin
    rd_ptr_pre   = rd_ptr - AW'(1);
    free         = DEPTH_C - count;
    data_out     = bypass ? data_in : storage[rd_ptr];
    data_out_pre = storage[rd_ptr_pre];
    empty        = (count == '0);
    full         = 32'(free) < FULL_MARGIN;
    virtual_full = 32'(free) < VFULL_MARGIN;
  end

endmodule
